pifo_max_evict: RTL and testbench

PIFO_MAX_EVICT -- requirements
Module: pifo_max_evict

---
 rtl/pifo_max_evict.sv | 100 ++++++++++
 tb/tb_pifo_max_evict.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pifo_max_evict.sv
// Pipelined max-rank selector: a binary compare tree over REG_WIDTH lanes, one tree
// level per pipeline stage, with a valid/ready handshake on both sides.
module pifo_max_evict #(
    parameter int REG_WIDTH  = 4,
    parameter int IDX_WIDTH  = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                            axis_aclk,
    input  logic                            axis_resetn,
    input  logic [REG_WIDTH*DATA_WIDTH-1:0] data_in,
    input  logic [REG_WIDTH*IDX_WIDTH-1:0]  idx_in,
    input  logic [REG_WIDTH-1:0]            vld_in,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [DATA_WIDTH-1:0]           max_out,
    output logic [IDX_WIDTH-1:0]            idx_out,
    output logic                            found_out,
    output logic                            out_valid,
    input  logic                            out_ready
);

    // Tree nodes are numbered heap-style: node n combines sources 2n and 2n+1, where
    // sources 0..REG_WIDTH-1 are the input lanes and source REG_WIDTH+n is node n.
    localparam int NODES = REG_WIDTH - 1;
    localparam int SRCS  = 2 * REG_WIDTH - 2;

    logic [DATA_WIDTH-1:0] node_data [NODES];
    logic [IDX_WIDTH-1:0]  node_idx  [NODES];
    logic [NODES-1:0]      node_vld;
    logic [IDX_WIDTH-1:0]  lvl_valid;

    logic [DATA_WIDTH-1:0] src_data [SRCS];
    logic [IDX_WIDTH-1:0]  src_idx  [SRCS];
    logic [SRCS-1:0]       src_vld;

    logic [DATA_WIDTH-1:0] nxt_data [NODES];
    logic [IDX_WIDTH-1:0]  nxt_idx  [NODES];
    logic [NODES-1:0]      nxt_vld;

    logic advance;

    assign out_valid = lvl_valid[IDX_WIDTH-1];
    assign advance   = !(out_valid && !out_ready);
    assign in_ready  = advance && axis_resetn;

    assign max_out   = node_data[NODES-1];
    assign idx_out   = node_idx[NODES-1];
    assign found_out = node_vld[NODES-1];

    always_comb begin
        for (int i = 0; i < REG_WIDTH; i++) begin
            src_data[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            src_idx[i]  = idx_in[i*IDX_WIDTH +: IDX_WIDTH];
            src_vld[i]  = vld_in[i];
        end
        for (int n = 0; n < NODES - 1; n++) begin
            src_data[REG_WIDTH+n] = node_data[n];
            src_idx[REG_WIDTH+n]  = node_idx[n];
            src_vld[REG_WIDTH+n]  = node_vld[n];
        end
    end

    // Odd child wins ties so the overall winner is the highest-numbered maximal lane.
    always_comb begin
        for (int n = 0; n < NODES; n++) begin
            nxt_data[n] = '0;
            nxt_idx[n]  = '0;
            nxt_vld[n]  = src_vld[2*n] | src_vld[2*n+1];
            if (src_vld[2*n+1] && (!src_vld[2*n] || (src_data[2*n+1] >= src_data[2*n]))) begin
                nxt_data[n] = src_data[2*n+1];
                nxt_idx[n]  = src_idx[2*n+1];
            end else if (src_vld[2*n]) begin
                nxt_data[n] = src_data[2*n];
                nxt_idx[n]  = src_idx[2*n];
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            lvl_valid <= '0;
            node_vld  <= '0;
            for (int n = 0; n < NODES; n++) begin
                node_data[n] <= '0;
                node_idx[n]  <= '0;
            end
        end else if (advance) begin
            lvl_valid[0] <= in_valid && in_ready;
            for (int k = 1; k < IDX_WIDTH; k++) begin
                lvl_valid[k] <= lvl_valid[k-1];
            end
            node_vld <= nxt_vld;
            for (int n = 0; n < NODES; n++) begin
                node_data[n] <= nxt_data[n];
                node_idx[n]  <= nxt_idx[n];
            end
        end
    end

endmodule

// File: tb/tb_pifo_max_evict.sv
// Self-checking bench for pifo_max_evict: directed scenarios plus a randomized
// run scored against a queue-based "highest valid rank, highest lane on tie" model.
module tb_pifo_max_evict;

    localparam int RW = 4;
    localparam int IW = 2;
    localparam int DW = 8;
    localparam int N_RAND = 10000;
    localparam int CYCLE_LIMIT = 80000;
    localparam logic [7:0] IDX_STD = {2'd3, 2'd2, 2'd1, 2'd0};

    typedef struct packed {
        logic       f;
        logic [1:0] i;
        logic [7:0] m;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   data_in;
    logic [7:0]    idx_in;
    logic [3:0]    vld_in;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    max_out;
    logic [1:0]    idx_out;
    logic          found_out;
    logic          out_valid;
    logic          out_ready;

    int checks = 0;
    int errors = 0;

    pifo_max_evict #(
        .REG_WIDTH (RW),
        .IDX_WIDTH (IW),
        .DATA_WIDTH(DW)
    ) dut (
        .axis_aclk  (clk),
        .axis_resetn(rst_n),
        .data_in    (data_in),
        .idx_in     (idx_in),
        .vld_in     (vld_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .max_out    (max_out),
        .idx_out    (idx_out),
        .found_out  (found_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pack4(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
        return {d, c, b, a};
    endfunction

    // {out_valid, found_out, idx_out, max_out}
    function automatic logic [11:0] obs();
        return {out_valid, found_out, idx_out, max_out};
    endfunction

    function automatic res_t ref_max(input logic [31:0] dp, input logic [7:0] ip,
                                     input logic [3:0] v);
        res_t r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (v[i] && (!r.f || dp[i*8 +: 8] >= r.m)) begin
                r.f = 1'b1;
                r.m = dp[i*8 +: 8];
                r.i = ip[i*2 +: 2];
            end
        end
        return r;
    endfunction

    task automatic drive(input logic [31:0] d, input logic [7:0] ix, input logic [3:0] v,
                         input logic iv);
        data_in  = d;
        idx_in   = ix;
        vld_in   = v;
        in_valid = iv;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(pack4(8'd1, 8'd2, 8'd3, 8'd4), IDX_STD, 4'b1111, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (obs() !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", obs(), 12'h000);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL idle_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        out_ready = 1'b1;
        drive(pack4(8'd3, 8'd9, 8'd5, 8'd7), IDX_STD, 4'b1111, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_early: got out_valid %b expected 0", out_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (obs() !== {1'b1, 1'b1, 2'd1, 8'd9}) begin
            errors++;
            $display("[TB] FAIL basic_result: got %h expected %h", obs(), {1'b1, 1'b1, 2'd1, 8'd9});
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_single_cycle: got out_valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_tie();
        @(negedge clk);
        drive(pack4(8'd8, 8'd8, 8'd2, 8'd8), IDX_STD, 4'b1111, 1'b1);
        @(negedge clk);
        drive(pack4(8'd8, 8'd8, 8'd2, 8'd8), IDX_STD, 4'b0111, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (obs() !== {1'b1, 1'b1, 2'd3, 8'd8}) begin
            errors++;
            $display("[TB] FAIL tie_all_valid: got %h expected %h", obs(), {1'b1, 1'b1, 2'd3, 8'd8});
        end
        @(negedge clk);
        #1;
        checks++;
        if (obs() !== {1'b1, 1'b1, 2'd1, 8'd8}) begin
            errors++;
            $display("[TB] FAIL tie_partial: got %h expected %h", obs(), {1'b1, 1'b1, 2'd1, 8'd8});
        end
        @(negedge clk);
    endtask

    task automatic test_empty();
        @(negedge clk);
        drive(pack4(8'd200, 8'd150, 8'd99, 8'd250), 8'b01101100, 4'b0000, 1'b1);
        @(negedge clk);
        drive(pack4(8'd200, 8'd150, 8'd1, 8'd250), IDX_STD, 4'b0100, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (obs() !== {1'b1, 1'b0, 2'd0, 8'd0}) begin
            errors++;
            $display("[TB] FAIL empty_request: got %h expected %h", obs(), {1'b1, 1'b0, 2'd0, 8'd0});
        end
        @(negedge clk);
        #1;
        checks++;
        if (obs() !== {1'b1, 1'b1, 2'd2, 8'd1}) begin
            errors++;
            $display("[TB] FAIL single_lane: got %h expected %h", obs(), {1'b1, 1'b1, 2'd2, 8'd1});
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back_stall();
        logic [11:0] exp_r1;
        exp_r1 = {1'b1, 1'b1, 2'd3, 8'd4};
        @(negedge clk);
        out_ready = 1'b1;
        drive(pack4(8'd1, 8'd2, 8'd3, 8'd4), IDX_STD, 4'b1111, 1'b1);
        @(negedge clk);
        drive(pack4(8'd10, 8'd0, 8'd0, 8'd0), IDX_STD, 4'b1111, 1'b1);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            drive(pack4(8'd5, 8'd6, 8'd50, 8'd7), IDX_STD, 4'b1111, 1'b1);
            out_ready = 1'b0;
            #1;
            checks++;
            if (obs() !== exp_r1) begin
                errors++;
                $display("[TB] FAIL stall_hold[%0d]: got %h expected %h", s, obs(), exp_r1);
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_in_ready[%0d]: got %b expected 0", s, in_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (obs() !== exp_r1 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_release: got %h/%b expected %h/1", obs(), in_ready, exp_r1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (obs() !== {1'b1, 1'b1, 2'd0, 8'd10}) begin
            errors++;
            $display("[TB] FAIL stall_second: got %h expected %h", obs(), {1'b1, 1'b1, 2'd0, 8'd10});
        end
        @(negedge clk);
        #1;
        checks++;
        if (obs() !== {1'b1, 1'b1, 2'd2, 8'd50}) begin
            errors++;
            $display("[TB] FAIL stall_third: got %h expected %h", obs(), {1'b1, 1'b1, 2'd2, 8'd50});
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_drained: got out_valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        out_ready = 1'b1;
        drive(pack4(8'd40, 8'd41, 8'd42, 8'd43), IDX_STD, 4'b1111, 1'b1);
        @(negedge clk);
        drive(pack4(8'd60, 8'd61, 8'd62, 8'd63), IDX_STD, 4'b1111, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checks++;
        if (obs() !== 12'h000 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midflight_reset: got %h/%b expected 000/0", obs(), in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(pack4(8'd17, 8'd200, 8'd3, 8'd200), IDX_STD, 4'b1011, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midflight_stale: got out_valid %b expected 0", out_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (obs() !== {1'b1, 1'b1, 2'd3, 8'd200}) begin
            errors++;
            $display("[TB] FAIL post_reset_first: got %h expected %h", obs(), {1'b1, 1'b1, 2'd3, 8'd200});
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_drain: got out_valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_random();
        res_t        q[$];
        res_t        front;
        int          sent;
        int          cycles;
        logic [31:0] dp;
        logic [7:0]  ip;
        logic [3:0]  v;
        sent   = 0;
        cycles = 0;
        while ((sent < N_RAND || q.size() > 0) && cycles < CYCLE_LIMIT) begin
            @(negedge clk);
            cycles++;
            for (int i = 0; i < 4; i++) begin
                dp[i*8 +: 8] = ($urandom % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
                ip[i*2 +: 2] = 2'($urandom_range(0, 3));
            end
            v = 4'($urandom_range(0, 15));
            drive(dp, ip, v, (sent < N_RAND) && ($urandom % 4 != 0));
            out_ready = ($urandom % 10) < 7;
            #1;
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rand_extra: got %h expected no result", obs());
                end else begin
                    front = q[0];
                    if ({found_out, idx_out, max_out} !== front) begin
                        errors++;
                        $display("[TB] FAIL rand_result: got %h expected %h", {found_out, idx_out, max_out}, front);
                    end
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_max(dp, ip, v));
                sent++;
            end
        end
        checks++;
        if (sent != N_RAND || q.size() != 0) begin
            errors++;
            $display("[TB] FAIL rand_complete: got sent=%0d pending=%0d expected sent=%0d pending=0",
                     sent, q.size(), N_RAND);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rand_trailing: got out_valid %b expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_empty();
        test_back_to_back_stall();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
